// File: rtl/cpu_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
package cpu_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned PROD_W        = 2 * XLEN;
    localparam int unsigned ACC_W         = PROD_W + 1;
    localparam int unsigned MULDIV_CYCLES = 32;
    localparam int unsigned CNT_W         = $clog2(MULDIV_CYCLES);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } muldiv_op_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Two's-complement negate when en is set.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
        return en ? XLEN'(-v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if;
    import cpu_pkg::*;

    logic              start;
    muldiv_op_t        op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic              busy;
    logic              done;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
module muldiv_step
    import cpu_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [XLEN-1:0]  operand,
    input  logic             is_div,
    output logic [ACC_W-1:0] acc_next
);

    logic [XLEN:0]    upper_add;
    logic [ACC_W-1:0] shl;
    logic [XLEN:0]    diff;

    // Mult: acc = {partial_hi[32:0], multiplier[31:0]}; Div: acc = {remainder[32:0], quotient[31:0]}.
    always_comb begin
        acc_next  = '0;
        upper_add = acc[ACC_W-1:XLEN] + (acc[0] ? {1'b0, operand} : (XLEN+1)'(0));
        shl       = {acc[ACC_W-2:0], 1'b0};
        diff      = shl[ACC_W-1:XLEN] - {1'b0, operand};
        if (is_div) begin
            if (shl[ACC_W-1:XLEN] >= {1'b0, operand}) begin
                acc_next = {diff, shl[XLEN-1:1], 1'b1};
            end else begin
                acc_next = shl;
            end
        end else begin
            acc_next = {1'b0, upper_add, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; also services MTHI/MTLO.
module muldiv_unit
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    muldiv_unit_if.slave bus
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             busy_q;
    logic             busy_nxt;
    logic             done_q;
    logic             done_nxt;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [XLEN-1:0]  operand;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;

    logic             accept_c;
    logic             arith_c;
    logic             signed_c;
    logic             div_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [XLEN-1:0]  a_mag_c;
    logic [XLEN-1:0]  b_mag_c;
    logic [PROD_W-1:0] prod_fix_c;
    logic [XLEN-1:0]  q_fix_c;
    logic [XLEN-1:0]  r_fix_c;

    always_comb begin
        accept_c = bus.start && (state == ST_IDLE);
        arith_c  = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                   (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        signed_c = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        div_c    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        a_neg_c  = signed_c && bus.a[XLEN-1];
        b_neg_c  = signed_c && bus.b[XLEN-1];
        a_mag_c  = neg_if(bus.a, a_neg_c);
        b_mag_c  = neg_if(bus.b, b_neg_c);
    end

    // Sign fixup applied on the FIX edge.
    always_comb begin
        prod_fix_c = neg_q ? PROD_W'(-acc[PROD_W-1:0]) : acc[PROD_W-1:0];
        q_fix_c    = neg_if(acc[XLEN-1:0], neg_q);
        r_fix_c    = neg_if(acc[PROD_W-1:XLEN], neg_r);
    end

    muldiv_step u_step (
        .acc      (acc),
        .operand  (operand),
        .is_div   (is_div),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_nxt = 1'b0;
                if (accept_c && arith_c) begin
                    state_nxt = ST_RUN;
                    busy_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                if (count == CNT_W'(MULDIV_CYCLES - 1)) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Datapath: operand latch, iteration, HI/LO writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c && arith_c) begin
                        count   <= '0;
                        is_div  <= div_c;
                        operand <= div_c ? b_mag_c : a_mag_c;
                        acc     <= {(XLEN+1)'(0), div_c ? a_mag_c : b_mag_c};
                        // A zero divisor keeps the all-ones quotient unsigned.
                        neg_q   <= (a_neg_c ^ b_neg_c) && !(div_c && (bus.b == '0));
                        neg_r   <= a_neg_c;
                    end else if (accept_c && (bus.op == OP_MTHI)) begin
                        hi_q <= bus.a;
                    end else if (accept_c && (bus.op == OP_MTLO)) begin
                        lo_q <= bus.a;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    count <= count + CNT_W'(1);
                end
                ST_FIX: begin
                    if (is_div) begin
                        hi_q <= r_fix_c;
                        lo_q <= q_fix_c;
                    end else begin
                        {hi_q, lo_q} <= prod_fix_c;
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops vs an arithmetic model.
module tb_muldiv_unit;
    import cpu_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Architectural result {hi,lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Entered just after a negedge; issues one op and, for arithmetic ops, waits for done.
    // inject >= 0 pulses an MTLO that many cycles into the op (must be ignored).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int inject);
        logic [63:0] r;
        int n, busy_cnt;
        bus.start = 1'b1;
        bus.op    = muldiv_op_t'(op);
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        if (op <= 3'd3) begin
            r = ref_model(op, a, b);
            chk("busy_after_start", 64'(bus.busy), 64'd1);
            chk("hold_hilo", {bus.hi, bus.lo}, {exp_hi, exp_lo});
            n = 0;
            busy_cnt = 0;
            while (!bus.done && n < 60) begin
                if (bus.busy) busy_cnt++;
                if (inject >= 0 && n == inject) begin
                    bus.start = 1'b1;
                    bus.op    = OP_MTLO;
                    bus.a     = 32'hDEAD_BEEF;
                end else begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
                n++;
            end
            bus.start = 1'b0;
            chk("done_seen", 64'(bus.done), 64'd1);
            chk("busy_cycles", 64'(busy_cnt), 64'd33);
            exp_hi = r[63:32];
            exp_lo = r[31:0];
            chk($sformatf("result_op%0d", op), {bus.hi, bus.lo}, r);
            chk("busy_at_done", 64'(bus.busy), 64'd0);
        end else begin
            if (op == 3'd4) exp_hi = a;
            if (op == 3'd5) exp_lo = a;
            chk($sformatf("move_op%0d", op), {bus.hi, bus.lo}, {exp_hi, exp_lo});
            chk("move_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        end
    endtask

    initial begin
        int dones;
        logic [2:0] rop;
        logic [31:0] ra, rb;
        n_cmp = 0;
        n_bad = 0;
        exp_hi = '0;
        exp_lo = '0;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_state", {30'd0, bus.busy, bus.done, bus.hi, bus.lo}, 64'd0);

        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
        chk("multu_max", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
        @(negedge clk);
        chk("done_one_pulse", 64'(bus.done), 64'd0);

        run_op(3'd0, 32'hFFFFFFFD, 32'd5, -1);
        chk("mult_neg", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);
        // Back-to-back: issued in the done cycle.
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, -1);
        chk("div_neg", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, -1);
        chk("div_wrap", {bus.hi, bus.lo}, 64'h00000000_80000000);
        run_op(3'd3, 32'd7, 32'd0, -1);
        chk("divu_zero", {bus.hi, bus.lo}, 64'h00000007_FFFFFFFF);
        run_op(3'd2, 32'hFFFFFFF9, 32'd0, -1);

        run_op(3'd4, 32'h12345678, 32'd0, -1);
        chk("mthi", 64'(bus.hi), 64'h12345678);
        run_op(3'd3, 32'd100, 32'd7, 5);
        chk("divu_100_7_mtlo_ignored", {bus.hi, bus.lo}, {32'd2, 32'd14});

        // Reserved op does nothing.
        run_op(3'd6, 32'hAAAA5555, 32'd1, -1);
        run_op(3'd7, 32'h5555AAAA, 32'd1, -1);

        // Abort mid-run with reset; no done may follow.
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        chk("abort_clear", {30'd0, bus.busy, bus.done, bus.hi, bus.lo}, 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        run_op(3'd1, 32'd6, 32'd7, -1);
        chk("multu_6_7", {bus.hi, bus.lo}, 64'd42);

        // Reset beats a simultaneous start.
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = 32'h0BAD_0BAD;
        @(negedge clk);
        bus.op    = OP_MULTU;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        chk("reset_wins", {30'd0, bus.busy, bus.done, bus.hi, bus.lo}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 6));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 4) == 0) rb = 32'($urandom_range(0, 15)) - 32'd8;
            run_op(rop, ra, rb, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
